// File: rtl/wb_grf_unit_pkg.sv
// Shared decode constants and write-back select encoding for the W-stage
// register-file unit.
package wb_grf_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_COP0    = 6'b010000;

    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // rs field value that marks mfc0 inside the COP0 opcode space
    localparam logic [4:0] RS_MFC0    = 5'b00000;

    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_DM   = 3'd1,
        WB_HI   = 3'd2,
        WB_LO   = 3'd3,
        WB_CP0  = 3'd4,
        WB_LINK = 3'd5
    } wb_sel_e;

endpackage

// File: rtl/wb_sel_decode.sv
// Pure combinational write-back source decode of the W-stage instruction.
module wb_sel_decode
    import wb_grf_unit_pkg::*;
(
    input  logic [31:0] instr,
    output wb_sel_e     sel,
    output logic        bubble
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [5:0] fn;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign fn     = instr[5:0];
    assign bubble = (instr == 32'd0);

    always_comb begin
        sel = WB_ALU;
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: sel = WB_DM;
            OP_JAL:                              sel = WB_LINK;
            OP_COP0: begin
                if (rs == RS_MFC0) sel = WB_CP0;
            end
            OP_SPECIAL: begin
                case (fn)
                    FN_MFHI: sel = WB_HI;
                    FN_MFLO: sel = WB_LO;
                    FN_JALR: sel = WB_LINK;
                    default: sel = WB_ALU;
                endcase
            end
            default: sel = WB_ALU;
        endcase
    end

endmodule

// File: rtl/wb_grf_unit.sv
// W-stage write-back select, 32x32 register file with two read ports and a
// retired-instruction counter. Define WB_BYPASS_EN for same-cycle write-through reads.
module wb_grf_unit
    import wb_grf_unit_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      W_Instr,
    input  logic [31:0]      W_PC,
    input  logic [4:0]       W_A3,
    input  logic [1:0]       W_Tnew,
    input  logic [31:0]      W_ALUResult,
    input  logic [31:0]      W_DMRD,
    input  logic [31:0]      W_HI,
    input  logic [31:0]      W_LO,
    input  logic [31:0]      W_CP0_out,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      W_WD,
    output logic             W_fwd_ok,
    output logic [CNT_W-1:0] instret
);

    wb_sel_e     sel;
    logic        bubble;
    logic [31:0] regs [NREG];

    wb_sel_decode u_sel_decode (
        .instr  (W_Instr),
        .sel    (sel),
        .bubble (bubble)
    );

    always_comb begin
        W_WD = W_ALUResult;
        if (bubble) begin
            W_WD = 32'd0;
        end else begin
            case (sel)
                WB_DM:   W_WD = W_DMRD;
                WB_HI:   W_WD = W_HI;
                WB_LO:   W_WD = W_LO;
                WB_CP0:  W_WD = W_CP0_out;
                WB_LINK: W_WD = W_PC + 32'd8;
                default: W_WD = W_ALUResult;
            endcase
        end
    end

    assign W_fwd_ok = (W_A3 != 5'd0) && (W_Tnew == 2'd0);

    // An illegal nonzero Tnew still commits; it only blocks forwarding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (W_A3 != 5'd0) begin
            regs[W_A3] <= W_WD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (W_PC != 32'd0) begin
            instret <= instret + CNT_W'(1);
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rs_data = 32'd0;
        rt_data = 32'd0;
        if (rs_addr != 5'd0) begin
            rs_data = (W_fwd_ok && rs_addr == W_A3) ? W_WD : regs[rs_addr];
        end
        if (rt_addr != 5'd0) begin
            rt_data = (W_fwd_ok && rt_addr == W_A3) ? W_WD : regs[rt_addr];
        end
    end
`else
    assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];
`endif

endmodule
